// File: rtl/div_share_arbiter.sv
// Round-robin sequencer that time-shares one combinational divider among N_REQ requesters.
// Operands are registered onto the divider, sampled after LATENCY settle cycles, and returned tagged with the requester ID.
module div_share_arbiter #(
  parameter int WIDTH   = 8,
  parameter int N_REQ   = 3,
  parameter int LATENCY = 2,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*WIDTH-1:0]  req_dividend,
  input  logic [N_REQ*WIDTH-1:0]  req_divisor,
  output logic [WIDTH-1:0]        div_dividend,
  output logic [WIDTH-1:0]        div_divisor,
  input  logic [WIDTH-1:0]        div_quotient,
  input  logic [WIDTH-1:0]        div_remainder,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [WIDTH-1:0]        rsp_quotient,
  output logic [WIDTH-1:0]        rsp_remainder,
  output logic                    rsp_dbz,
  output logic                    busy
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   div_dividend_q, div_divisor_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic [WIDTH-1:0]   rsp_quo_q, rsp_rem_q;
  logic               rsp_dbz_q;

  logic               grant_vld;
  logic [PTR_W-1:0]   grant_idx;
  logic [WIDTH-1:0]   sel_dividend, sel_divisor;
  logic               accept;

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s[PTR_W-1:0];
  endfunction

  // Scan from the farthest offset back to rr_ptr so the nearest valid requester wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      if (req_valid[ptr_add(rr_ptr_q, off)]) begin
        grant_vld = 1'b1;
        grant_idx = ptr_add(rr_ptr_q, off);
      end
    end
  end

  always_comb begin
    sel_dividend = '0;
    sel_divisor  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == PTR_W'(i)) begin
        sel_dividend = req_dividend[i*WIDTH +: WIDTH];
        sel_divisor  = req_divisor[i*WIDTH +: WIDTH];
      end
    end
  end

  assign accept = (state_q == IDLE) && grant_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (sel_divisor == '0) ? RESP : WAIT;
      WAIT: if (cnt_q == '0) state_d = RESP;
      RESP: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (rst_n && (state_q == IDLE) && grant_vld) req_ready[grant_idx] = 1'b1;
    rsp_valid = (state_q == RESP);
    busy      = (state_q != IDLE);
  end

  // Divide-by-zero bypasses the divider entirely and answers on the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q       <= '0;
      cnt_q          <= '0;
      div_dividend_q <= '0;
      div_divisor_q  <= '0;
      rsp_id_q       <= '0;
      rsp_quo_q      <= '0;
      rsp_rem_q      <= '0;
      rsp_dbz_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          div_dividend_q <= sel_dividend;
          div_divisor_q  <= sel_divisor;
          rsp_id_q       <= ID_W'(grant_idx);
          rr_ptr_q       <= ptr_add(grant_idx, 1);
          cnt_q          <= CNT_W'(LATENCY - 1);
          if (sel_divisor == '0) begin
            rsp_quo_q <= '1;
            rsp_rem_q <= sel_dividend;
            rsp_dbz_q <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            rsp_quo_q <= div_quotient;
            rsp_rem_q <= div_remainder;
            rsp_dbz_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign div_dividend  = div_dividend_q;
  assign div_divisor   = div_divisor_q;
  assign rsp_id        = rsp_id_q;
  assign rsp_quotient  = rsp_quo_q;
  assign rsp_remainder = rsp_rem_q;
  assign rsp_dbz       = rsp_dbz_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Scoreboard bench for div_share_arbiter: directed requests push expected responses, a monitor pops on each handoff.
module tb_div_share_arbiter;
  localparam int W = 8;
  localparam int N = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_dividend, req_divisor;
  logic [W-1:0]     div_dividend, div_divisor, div_quotient, div_remainder;
  logic             rsp_valid, rsp_ready, rsp_dbz, busy;
  logic [1:0]       rsp_id;
  logic [W-1:0]     rsp_quotient, rsp_remainder;

  always #5 clk = ~clk;

  div_share_arbiter #(.WIDTH(W), .N_REQ(N), .LATENCY(2), .ID_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_dbz(rsp_dbz), .busy(busy)
  );

  // Shared combinational divider seen by the arbiter.
  assign div_quotient  = (div_divisor == '0) ? '1 : div_dividend / div_divisor;
  assign div_remainder = (div_divisor == '0) ? div_dividend : div_dividend % div_divisor;

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input int id, input int q, input int r, input int dbz);
    exp_t t;
    t.id  = 2'(id);
    t.q   = W'(q);
    t.r   = W'(r);
    t.dbz = dbz[0];
    sb.push_back(t);
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_dividend[i*W +: W] = a;
    req_divisor[i*W +: W]  = b;
    req_valid[i]           = 1'b1;
  endtask

  // Waits for a grant, then lets the accepting edge pass; g=-1 on timeout.
  task automatic accept_any(output int g);
    g = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (|req_ready) begin
        for (int k = 0; k < N; k++) if (req_ready[k]) g = k;
        break;
      end
    end
    if (g < 0) begin
      checks++;
      failures++;
      $display("FAIL grant_timeout actual=none expected=grant");
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle_reached", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int i, input int a, input int b, input int q, input int r,
                        input int dbz, input int lat);
    int g;
    int n;
    set_req(i, W'(a), W'(b));
    accept_any(g);
    chk("op_grant", 32'(g), 32'(i));
    if (g >= 0) push_exp(i, q, r, dbz);
    req_valid = '0;
    chk("op_busy", 32'(busy), 32'd1);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("op_latency", 32'(n), 32'(lat));
    wait_idle();
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected actual id=%0d q=%0d expected=none", rsp_id, rsp_quotient);
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
          chk("rsp_quotient", 32'(rsp_quotient), 32'(mon_e.q));
          chk("rsp_remainder", 32'(rsp_remainder), 32'(mon_e.r));
          chk("rsp_dbz", 32'(rsp_dbz), 32'(mon_e.dbz));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   g;
    logic quiet;
    logic stable;

    rst_n        = 1'b0;
    req_valid    = '1;
    req_dividend = '0;
    req_divisor  = '0;
    rsp_ready    = 1'b1;
    #3;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_div_operands", 32'({div_dividend, div_divisor}), 32'd0);
    chk("rst_rsp_data", 32'({rsp_id, rsp_quotient, rsp_remainder, rsp_dbz}), 32'd0);
    repeat (2) @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of WAIT discards the operation.
    set_req(0, 8'd200, 8'd7);
    accept_any(g);
    chk("rst_op_grant", 32'(g), 32'd0);
    req_valid = '0;
    chk("rst_op_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_div_operands", 32'({div_dividend, div_divisor}), 32'd0);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid || busy) quiet = 1'b0;
    end
    chk("rst_discard", 32'(quiet), 32'd1);
    @(posedge clk);
    #1;

    // Round robin with all three continuously valid.
    set_req(0, 8'd100, 8'd9);
    set_req(1, 8'd255, 8'd16);
    set_req(2, 8'd7, 8'd8);
    for (int k = 0; k < 4; k++) begin
      accept_any(g);
      chk("rr_grant", 32'(g), 32'(k % 3));
      if (g >= 0) begin
        case (k % 3)
          0: push_exp(0, 11, 1, 0);
          1: push_exp(1, 15, 15, 0);
          default: push_exp(2, 0, 7, 0);
        endcase
      end
    end
    req_valid = '0;
    wait_idle();

    run_op(1, 12, 3, 4, 0, 0, 2);
    run_op(0, 77, 0, 255, 77, 1, 0);

    // Backpressure: response held while req2 waits.
    rsp_ready = 1'b0;
    set_req(1, 8'd50, 8'd5);
    accept_any(g);
    chk("bp_grant", 32'(g), 32'd1);
    if (g >= 0) push_exp(1, 10, 0, 0);
    req_valid = '0;
    set_req(2, 8'd9, 8'd4);
    for (int n = 0; n < 20 && !rsp_valid; n++) begin
      @(posedge clk);
      #1;
    end
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!rsp_valid || rsp_quotient != 8'd10 || rsp_remainder != 8'd0 ||
          rsp_id != 2'd1 || req_ready != 3'b000) stable = 1'b0;
    end
    chk("bp_stable", 32'(stable), 32'd1);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_handoff_valid", 32'(rsp_valid), 32'd0);
    chk("bp_next_ready", 32'(req_ready), 32'b100);
    push_exp(2, 2, 1, 0);
    @(posedge clk);
    #1;
    req_valid = '0;
    chk("bp_next_accept", 32'({busy, div_dividend}), 32'({1'b1, 8'd9}));
    wait_idle();

    run_op(0, 255, 255, 1, 0, 0, 2);
    run_op(1, 3, 200, 0, 3, 0, 2);

    repeat (3) @(posedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
